// File: rtl/veririsc_controller.sv
// VeriRISC instruction sequencer: an 8-phase cycle per instruction, decoding the
// IR opcode into load/enable strobes for the IR, AC, PC, memory and bus driver.
//
// state      | meaning
// INST_ADDR  | PC drives the address bus
// INST_FETCH | read instruction from memory
// INST_LOAD  | load instruction register
// IDLE       | hold IR load while the instruction settles
// OP_ADDR    | advance PC; HLT is detected here
// OP_FETCH   | read operand for ALU instructions
// ALU_OP     | SKZ test, JMP target load, STO drives the bus
// STORE      | AC load, STO write, JMP completes
module veririsc_controller #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t state, state_next;
  logic   halted, halted_next;
  logic   is_hlt, is_skz, is_sto, is_jmp, is_aluop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  always_comb begin
    is_hlt   = (opcode == OP_HLT);
    is_skz   = (opcode == OP_SKZ);
    is_sto   = (opcode == OP_STO);
    is_jmp   = (opcode == OP_JMP);
    is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);

    state_next  = phase_t'(3'(state + 3'd1));
    halted_next = halted;
    // A sticky halt parks the sequencer in OP_ADDR until reset.
    if (HALT_STICKY && (halted || (state == OP_ADDR && is_hlt))) begin
      halted_next = 1'b1;
      state_next  = state;
    end

    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;

    case (state)
      INST_ADDR: sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        // PC advances only on the first OP_ADDR cycle, even when halted.
        inc_pc = !halted;
        halt   = halted || is_hlt;
      end
      OP_FETCH: rd = is_aluop;
      ALU_OP: begin
        rd     = is_aluop;
        inc_pc = is_skz && zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      STORE: begin
        rd     = is_aluop;
        ld_ac  = is_aluop;
        inc_pc = is_jmp;
        ld_pc  = is_jmp;
        data_e = is_sto;
        wr     = is_sto;
      end
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_veririsc_controller.sv
// Scoreboard bench for veririsc_controller: a sticky-halt and a pulse-halt instance
// share stimulus; a phase-level reference model predicts every output cycle.
module tb_veririsc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;

  logic sel_s, rd_s, ld_ir_s, inc_pc_s, halt_s, ld_pc_s, data_e_s, ld_ac_s, wr_s;
  logic sel_p, rd_p, ld_ir_p, inc_pc_p, halt_p, ld_pc_p, data_e_p, ld_ac_p, wr_p;
  logic [2:0] phase_s, phase_p;
  logic [11:0] obs_s, obs_p;

  veririsc_controller #(.HALT_STICKY(1'b1)) dut_s (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel_s), .rd(rd_s), .ld_ir(ld_ir_s), .inc_pc(inc_pc_s), .halt(halt_s),
    .ld_pc(ld_pc_s), .data_e(data_e_s), .ld_ac(ld_ac_s), .wr(wr_s), .phase(phase_s)
  );

  veririsc_controller #(.HALT_STICKY(1'b0)) dut_p (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel_p), .rd(rd_p), .ld_ir(ld_ir_p), .inc_pc(inc_pc_p), .halt(halt_p),
    .ld_pc(ld_pc_p), .data_e(data_e_p), .ld_ac(ld_ac_p), .wr(wr_p), .phase(phase_p)
  );

  assign obs_s = {sel_s, rd_s, ld_ir_s, inc_pc_s, halt_s, ld_pc_s, data_e_s, ld_ac_s, wr_s, phase_s};
  assign obs_p = {sel_p, rd_p, ld_ir_p, inc_pc_p, halt_p, ld_pc_p, data_e_p, ld_ac_p, wr_p, phase_p};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } sb_t;

  sb_t   sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string tag     = "reset";
  event  chk_ev;

  // Reference model: phase number per instance plus the sticky halt flag.
  int ph_s = 0;
  int ph_p = 0;
  bit hd_s = 1'b0;

  // Output table by phase, written straight from the instruction timing chart.
  function automatic logic [11:0] exp_out(int p, int op, bit z, bit h);
    bit aluop;
    bit e_sel, e_rd, e_ldir, e_inc, e_halt, e_ldpc, e_de, e_ldac, e_wr;
    logic [2:0] pv;
    aluop  = (op >= 2 && op <= 5);
    e_sel  = (p <= 3);
    e_rd   = (p >= 1 && p <= 3) || (p >= 5 && aluop);
    e_ldir = (p == 2 || p == 3);
    e_inc  = (p == 4 && !h) || (p == 6 && op == 1 && z) || (p == 7 && op == 7);
    e_halt = h || (p == 4 && op == 0);
    e_ldpc = (p == 6 || p == 7) && op == 7;
    e_de   = (p == 6 || p == 7) && op == 6;
    e_ldac = (p == 7) && aluop;
    e_wr   = (p == 7) && op == 6;
    pv     = 3'(p);
    return {e_sel, e_rd, e_ldir, e_inc, e_halt, e_ldpc, e_de, e_ldac, e_wr, pv};
  endfunction

  task automatic model_reset();
    ph_s = 0;
    ph_p = 0;
    hd_s = 1'b0;
  endtask

  task automatic push_exp();
    sb_t e;
    e.tag = tag;
    e.exp = {exp_out(ph_s, int'(opcode), zero, hd_s), exp_out(ph_p, int'(opcode), zero, 1'b0)};
    sb.push_back(e);
  endtask

  // One clock: advance the model on the edge, then drive new inputs and predict.
  task automatic cycle(input bit r, input int op, input bit z, input bit rnd);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (!hd_s) begin
        if (ph_s == 4 && opcode == 3'd0) hd_s = 1'b1;
        else ph_s = (ph_s + 1) % 8;
      end
      ph_p = (ph_p + 1) % 8;
    end
    #1;
    rst = r;
    if (rnd) begin
      if (ph_p == 0) opcode = 3'($urandom_range(0, 7));
      zero = 1'($urandom);
    end else begin
      opcode = 3'(op);
      zero   = z;
    end
    if (r) model_reset();
    push_exp();
  endtask

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if ({obs_s, obs_p} !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got sticky=%b pulse=%b expected sticky=%b pulse=%b",
                   e.tag, obs_s, obs_p, e.exp[23:12], e.exp[11:0]);
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b0;
    opcode = 3'd0;
    zero = 1'b0;
    #1 rst = 1'b1;

    tag = "reset";
    repeat (2) cycle(1'b1, 2, 1'b0, 1'b0);

    tag = "add";
    repeat (16) cycle(1'b0, 2, 1'b0, 1'b0);
    tag = "sto";
    repeat (8) cycle(1'b0, 6, 1'b0, 1'b0);
    tag = "skz_z1";
    repeat (8) cycle(1'b0, 1, 1'b1, 1'b0);
    tag = "skz_z0";
    repeat (8) cycle(1'b0, 1, 1'b0, 1'b0);
    tag = "jmp";
    repeat (8) cycle(1'b0, 7, 1'b0, 1'b0);
    tag = "logic_ops";
    for (int op = 3; op <= 5; op++) repeat (8) cycle(1'b0, op, 1'b1, 1'b0);

    // Asynchronous reset in ALU_OP of a store, checked before the next edge.
    tag = "sto_pre_rst";
    repeat (7) cycle(1'b0, 6, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1;
    tag = "async_rst";
    push_exp();
    ->chk_ev;
    cycle(1'b1, 6, 1'b0, 1'b0);

    tag = "hlt";
    repeat (28) cycle(1'b0, 0, 1'b0, 1'b0);
    tag = "hlt_zero";
    repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);
    tag = "hlt_rst";
    cycle(1'b1, 2, 1'b0, 1'b0);
    tag = "after_hlt";
    repeat (8) cycle(1'b0, 2, 1'b0, 1'b0);

    tag = "random";
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 49) == 0), 0, 1'b0, 1'b1);

    @(negedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
